launch_sequencer: RTL and testbench

Synthesizable run controller that drives a processor core's `Reset`/`Start`/`Ack` handshake in hardware. It replaces the hand-timed reset/start/wait sequence with a parametrised state machine. It launches the core `NUM_RUNS` times back to back, measures per-run latency in clock cycles, and flags hangs with a watchdog. It sits between a host or board-level control (`Go`/`Abort`) and the `TopLevel` core instance.

---
 rtl/launch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_launch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/launch_sequencer.sv
// Run controller that drives a core's reset/start/ack handshake NUM_RUNS times per Go edge
// and records per-run latency. Optional watchdog: define LAUNCH_TIMEOUT_EN.
module launch_sequencer #(
  parameter int NUM_RUNS     = 4,
  parameter int RESET_CYCLES = 2,
  parameter int START_CYCLES = 1,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 100000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Go,
  input  logic                          Abort,
  input  logic                          DutAck,
  output logic                          DutReset,
  output logic                          DutStart,
  output logic                          Busy,
  output logic                          Done,
  output logic                          TimedOut,
  output logic [$clog2(NUM_RUNS+1)-1:0] RunIdx,
  output logic [CNT_W-1:0]              LastCycles,
  output logic [CNT_W-1:0]              MaxCycles
);

  localparam int RUN_W  = $clog2(NUM_RUNS + 1);
  localparam int PH_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUNS       = RUN_W'(NUM_RUNS);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  if (NUM_RUNS < 1 || RESET_CYCLES < 1 || START_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("launch_sequencer: NUM_RUNS, RESET_CYCLES, START_CYCLES and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP, S_START, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               go_q;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RUN_W-1:0]   run_idx_q, run_idx_d, run_next;
  logic [CNT_W-1:0]   last_q, last_d, max_q, max_d;
  logic               timed_out_q, timed_out_d;
  logic               dut_reset_q, dut_reset_d, dut_start_q, dut_start_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               go_rise;

  assign go_rise  = Go & ~go_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign run_next = run_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    run_idx_d   = run_idx_q;
    last_d      = last_q;
    max_d       = max_q;
    timed_out_d = timed_out_q;

    if (Abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (go_rise) begin
          state_d     = S_RST;
          ph_d        = '0;
          run_idx_d   = '0;
          last_d      = '0;
          max_d       = '0;
          timed_out_d = 1'b0;
        end
        S_RST: begin
          if (ph_q == RST_LAST) state_d = S_GAP;
          else                  ph_d    = ph_q + 1'b1;
        end
        S_GAP: begin
          state_d = S_START;
          ph_d    = '0;
          cnt_d   = '0;
        end
        S_START: begin
          cnt_d = cnt_inc;
          if (ph_q == START_LAST) state_d = S_WAIT;
          else                    ph_d    = ph_q + 1'b1;
        end
        S_WAIT: begin
          cnt_d = cnt_inc;
          if (DutAck) begin
            last_d    = cnt_q;
            max_d     = (cnt_q > max_q) ? cnt_q : max_q;
            run_idx_d = run_next;
            if (run_next == RUNS) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RST;
              ph_d    = '0;
            end
`ifdef LAUNCH_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            // Watchdog abandons the remaining runs; ack in the same cycle wins above.
            timed_out_d = 1'b1;
            last_d      = CNT_W'(TIMEOUT);
            state_d     = S_DONE;
`endif
          end
        end
        S_DONE: if (!Go) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    dut_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
    dut_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b1;  // Go held high through reset must not look like an edge
      ph_q        <= '0;
      cnt_q       <= '0;
      run_idx_q   <= '0;
      last_q      <= '0;
      max_q       <= '0;
      timed_out_q <= 1'b0;
      dut_reset_q <= 1'b1;
      dut_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= Go;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      run_idx_q   <= run_idx_d;
      last_q      <= last_d;
      max_q       <= max_d;
      timed_out_q <= timed_out_d;
      dut_reset_q <= dut_reset_d;
      dut_start_q <= dut_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign DutReset   = dut_reset_q;
  assign DutStart   = dut_start_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign TimedOut   = timed_out_q;
  assign RunIdx     = run_idx_q;
  assign LastCycles = last_q;
  assign MaxCycles  = max_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// Directed bench for launch_sequencer: reset, nominal runs, latency stats, watchdog, abort, mid-run reset.
// Watchdog expectations follow LAUNCH_TIMEOUT_EN.
module tb_launch_sequencer;

  localparam int NUM_RUNS = 3;
  localparam int CNT_W    = 16;

  logic             Clk = 1'b0;
  logic             Reset, Go, Abort, DutAck;
  logic             DutReset, DutStart, Busy, Done, TimedOut;
  logic [1:0]       RunIdx;
  logic [CNT_W-1:0] LastCycles, MaxCycles;

  int checks = 0;
  int errors = 0;

  launch_sequencer #(
    .NUM_RUNS(NUM_RUNS), .RESET_CYCLES(2), .START_CYCLES(1), .CNT_W(CNT_W), .TIMEOUT(20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .Abort(Abort), .DutAck(DutAck),
    .DutReset(DutReset), .DutStart(DutStart), .Busy(Busy), .Done(Done),
    .TimedOut(TimedOut), .RunIdx(RunIdx), .LastCycles(LastCycles), .MaxCycles(MaxCycles)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL sim_time_limit: observed still running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dutreset"}, 32'(DutReset),   1);
    check({tag, "_dutstart"}, 32'(DutStart),   0);
    check({tag, "_busy"},     32'(Busy),       0);
    check({tag, "_done"},     32'(Done),       0);
    check({tag, "_timedout"}, 32'(TimedOut),   0);
    check({tag, "_runidx"},   32'(RunIdx),     0);
    check({tag, "_last"},     32'(LastCycles), 0);
    check({tag, "_max"},      32'(MaxCycles),  0);
  endtask

  // Advance to the first negedge showing DutStart high (the START cycle, counter 0).
  task automatic wait_start();
    int n = 0;
    while (DutStart !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("wait_start", 32'(DutStart), 1);
  endtask

  // Ack so that the captured counter equals lat.
  task automatic run_one(input int lat);
    wait_start();
    tick(lat);
    DutAck = 1'b1;
    tick(1);
    DutAck = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Go = 1'b1; Abort = 1'b0; DutAck = 1'b0;

    // Reset values, Go held high through reset
    tick(3);
    check_reset_values("reset");
    Reset = 1'b1;
    tick(3);
    check("go_held_busy", 32'(Busy), 0);
    check("go_held_dutreset", 32'(DutReset), 1);

    // Nominal: three runs of latency 6, shape checked on the first
    Go = 1'b0;
    tick(1);
    Go = 1'b1;
    tick(1);
    check("rst1_busy", 32'(Busy), 1);
    check("rst1_dutreset", 32'(DutReset), 1);
    tick(1);
    check("rst2_dutreset", 32'(DutReset), 1);
    tick(1);
    check("gap_dutreset", 32'(DutReset), 0);
    check("gap_dutstart", 32'(DutStart), 0);
    check("gap_busy", 32'(Busy), 1);
    tick(1);
    check("start_dutstart", 32'(DutStart), 1);
    tick(1);
    check("wait_dutstart", 32'(DutStart), 0);
    tick(5);
    DutAck = 1'b1;
    tick(1);
    DutAck = 1'b0;
    check("nom1_last", 32'(LastCycles), 6);
    check("nom1_max", 32'(MaxCycles), 6);
    check("nom1_runidx", 32'(RunIdx), 1);
    check("nom1_next_rst", 32'(DutReset), 1);
    run_one(6);
    run_one(6);
    check("nom_done", 32'(Done), 1);
    check("nom_busy", 32'(Busy), 0);
    check("nom_runidx", 32'(RunIdx), 3);
    check("nom_last", 32'(LastCycles), 6);
    check("nom_max", 32'(MaxCycles), 6);
    check("nom_done_dutreset", 32'(DutReset), 0);
    tick(3);
    check("done_held", 32'(Done), 1);
    check("done_no_restart", 32'(Busy), 0);
    Go = 1'b0;
    tick(1);
    check("idle_done", 32'(Done), 0);
    check("idle_dutreset", 32'(DutReset), 1);
    check("idle_runidx_kept", 32'(RunIdx), 3);

    // Varying latency, including the minimum (ack in the first WAIT cycle)
    Go = 1'b1;
    tick(1);
    check("clear_runidx", 32'(RunIdx), 0);
    check("clear_last", 32'(LastCycles), 0);
    check("clear_max", 32'(MaxCycles), 0);
    run_one(11);
    check("var1_last", 32'(LastCycles), 11);
    run_one(1);
    check("var2_last_min", 32'(LastCycles), 1);
    check("var2_max", 32'(MaxCycles), 11);
    check("var2_runidx", 32'(RunIdx), 2);
    run_one(8);
    check("var3_last", 32'(LastCycles), 8);
    check("var3_max", 32'(MaxCycles), 11);
    check("var3_done", 32'(Done), 1);
    Go = 1'b0;
    tick(1);
    check("var_idle_done", 32'(Done), 0);

    // Abort during the second run's START
    Go = 1'b1;
    tick(1);
    run_one(5);
    wait_start();
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    check("abort_busy", 32'(Busy), 0);
    check("abort_dutstart", 32'(DutStart), 0);
    check("abort_dutreset", 32'(DutReset), 1);
    check("abort_runidx", 32'(RunIdx), 1);
    check("abort_last", 32'(LastCycles), 5);
    tick(2);
    check("abort_no_relaunch", 32'(Busy), 0);
    Go = 1'b0;
    tick(1);
    Go = 1'b1;
    tick(1);
    check("rego_busy", 32'(Busy), 1);
    check("rego_runidx", 32'(RunIdx), 0);
    check("rego_last", 32'(LastCycles), 0);

    // Watchdog: ack stuck low
    wait_start();
    tick(20);
    check("wd_still_wait", 32'(Busy), 1);
    tick(1);
`ifdef LAUNCH_TIMEOUT_EN
    check("wd_timedout", 32'(TimedOut), 1);
    check("wd_done", 32'(Done), 1);
    check("wd_runidx", 32'(RunIdx), 0);
    check("wd_last", 32'(LastCycles), 20);
`else
    tick(1000);
    check("nowd_busy", 32'(Busy), 1);
    check("nowd_done", 32'(Done), 0);
    check("nowd_timedout", 32'(TimedOut), 0);
`endif

    // Reset during WAIT after one completed run
    Abort = 1'b1;
    tick(1);
    Abort = 1'b0;
    Go = 1'b0;
    tick(1);
    Go = 1'b1;
    tick(1);
    run_one(7);
    check("pre_reset_last", 32'(LastCycles), 7);
    wait_start();
    tick(3);
    check("pre_reset_busy", 32'(Busy), 1);
    Reset = 1'b0;
    DutAck = 1'b1;
    tick(1);
    check_reset_values("midreset");
    Reset = 1'b1;
    DutAck = 1'b0;
    tick(2);
    check("midreset_no_done", 32'(Done), 0);
    check("midreset_idle", 32'(Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
